// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the arbitrated UART transmitter: FSM states,
// frame geometry and the round-robin search used to pick the next owner.
package uart_arb_pkg;

  typedef enum logic [1:0] {StIdle, StOffer, StSend} arb_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DEF_DIV_W  = 16;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned IDX_W      = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First valid index at or after ptr, wrapping at num (num <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        num);
    rr_pick_t    res;
    int unsigned i;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      i = (32'(ptr) + k) % num;
      if (k < num && !res.found && valid[i[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = i[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first frame shifter with a per-frame sampled baud divisor.
// done_o pulses during the last cycle of the stop bit.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       data_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]      period_q, period_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '1;
      period_q <= '0;
      div_q    <= DIV_W'(1);
      bit_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      period_q <= period_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    shreg_d  = shreg_q;
    period_d = period_q;
    div_d    = div_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_o   = 1'b0;
    if (start_i && !busy_q) begin
      shreg_d  = {1'b1, data_i, 1'b0};
      div_d    = (div_i == '0) ? DIV_W'(1) : div_i;
      period_d = div_d - DIV_W'(1);
      bit_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (period_q == '0) begin
        if (bit_q == 4'(FRAME_BITS - 1)) begin
          done_o  = 1'b1;
          busy_d  = 1'b0;
          shreg_d = '1;
        end else begin
          shreg_d  = {1'b1, shreg_q[FRAME_BITS-1:1]};
          bit_d    = bit_q + 4'd1;
          period_d = div_q - DIV_W'(1);
        end
      end else begin
        period_d = period_q - DIV_W'(1);
      end
    end
  end

  // Idle shift register is all ones, so the line rests high.
  assign tx_o   = shreg_q[0];
  assign busy_o = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART line between byte requesters,
// with owner lock for multi-byte messages and active-low CTS gating.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     cfg_div_i,
  input  logic                 cts_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_lock_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 uart_tx_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     frames_sent_o
);

  localparam logic [NUM_REQ-1:0] GrantOne = NUM_REQ'(1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_REQ-1:0] valid_pad;
  rr_pick_t           pick;
  logic               owner_valid;
  logic               owner_lock;
  logic [7:0]         owner_data;
  logic               accept;
  logic               ser_busy;
  logic               ser_done;
  logic               ser_tx;

  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_REQ-1:0]   = req_valid_i;
    owner_valid              = |(req_valid_i & grant_q);
    owner_lock               = |(req_lock_i & grant_q);
    owner_data               = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_data = req_data_i[8*i +: 8];
    end
  end

  assign pick = rr_pick(valid_pad, ptr_q, NUM_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!cts_n_i && pick.found) begin
          grant_d = GrantOne << pick.idx;
          owner_d = pick.idx;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (accept) begin
          state_d = StSend;
        end else if (!owner_valid && !owner_lock) begin
          // Released without sending: pointer stays so fairness is unchanged.
          grant_d = '0;
          state_d = StIdle;
        end
      end
      StSend: begin
        if (ser_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (owner_lock) begin
            state_d = StOffer;
          end else begin
            grant_d = '0;
            state_d = StIdle;
            ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == StOffer) req_ready_o = grant_q & {NUM_REQ{~cts_n_i}};
  end

  assign accept = |(req_ready_o & req_valid_i);

  uart_tx_serializer #(
    .DIV_W(DIV_W)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start_i(accept),
    .data_i (owner_data),
    .div_i  (cfg_div_i),
    .tx_o   (ser_tx),
    .busy_o (ser_busy),
    .done_o (ser_done)
  );

  assign grant_o       = grant_q;
  assign uart_tx_o     = ser_tx;
  assign busy_o        = ser_busy;
  assign frames_sent_o = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a transaction-level
// schedule model, and line/grant logs checked against the expected frames.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int LOGN = 8192;

  typedef struct {
    int         s;
    int         r;
    logic [7:0] b;
    int         d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cfg_div;
  logic          cts_n;
  logic [N-1:0]  req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]  req_lock  = '0;
  logic [N-1:0]  ready;
  logic [N-1:0]  grant;
  logic          tx;
  logic          busy;
  logic [15:0]   frames;

  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic [N-1:0]  hs = '0;
  logic [7:0]    dq [N][$];
  logic [7:0]    mq [N][$];
  bit            lock_en [N];
  exp_t          expq [$];
  int            mptr = 0;
  int            mframes = 0;

  logic          line_log [LOGN];
  logic [N-1:0]  grant_log [LOGN];
  logic          busy_log [LOGN];

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DIV_W  (16),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_div_i    (cfg_div),
    .cts_n_i      (cts_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_lock_i   (req_lock),
    .req_ready_o  (ready),
    .grant_o      (grant),
    .uart_tx_o    (tx),
    .busy_o       (busy),
    .frames_sent_o(frames)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hs  <= req_valid & ready;
  end

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      line_log[cyc]  <= tx;
      grant_log[cyc] <= grant;
      busy_log[cyc]  <= busy;
    end
  end

  // Requesters: pop on handshake, present the next queued byte.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (hs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      req_valid[i]       = dq[i].size() > 0;
      req_data[8*i +: 8] = (dq[i].size() > 0) ? dq[i][0] : 8'h00;
      req_lock[i]        = lock_en[i] && dq[i].size() > 0;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int r, logic [7:0] b);
    dq[r].push_back(b);
    mq[r].push_back(b);
  endtask

  // Transaction-level schedule: all queued bytes presented at cycle t.
  task automatic model_run(int t, int d0, int d1);
    int         now;
    int         d;
    int         w;
    bit         more;
    logic [7:0] b;
    now = t + 2;
    d   = d0;
    forever begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && mq[(mptr + k) % N].size() > 0) w = (mptr + k) % N;
      end
      if (w < 0) break;
      more = 1'b1;
      while (more) begin
        b = mq[w].pop_front();
        expq.push_back('{s: now, r: w, b: b, d: d});
        mframes++;
        more = lock_en[w] && mq[w].size() > 0;
        now  = now + 10 * d + (more ? 1 : 2);
        d    = d1;
      end
      mptr = (w + 1) % N;
    end
  endtask

  task automatic check_frame(string tag, int idx, exp_t e);
    logic [9:0] bits;
    string      t;
    bits = {1'b1, e.b, 1'b0};
    t    = $sformatf("%s_f%0d", tag, idx);
    chk({t, "_idle"}, 32'(line_log[e.s-1]), 32'd1);
    chk({t, "_grant"}, 32'(grant_log[e.s-1]), 32'd1 << e.r);
    chk({t, "_startend"}, 32'(line_log[e.s+e.d-1]), 32'd0);
    chk({t, "_d0begin"}, 32'(line_log[e.s+e.d]), 32'(e.b[0]));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_bit%0d", t, k), 32'(line_log[e.s+k*e.d+e.d/2]), 32'(bits[k]));
    end
    chk({t, "_busy"}, 32'(busy_log[e.s+10*e.d-1]), 32'd1);
  endtask

  task automatic finish_check(string tag);
    exp_t last;
    last = expq[expq.size()-1];
    goto(last.s + 10 * last.d + 4);
    foreach (expq[k]) check_frame(tag, k, expq[k]);
    chk({tag, "_frames"}, 32'(frames), 32'(mframes % 65536));
    chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
    expq = {};
  endtask

  initial begin
    int         t;
    int         viol;
    int         d;
    int         n;
    bit         any;
    logic [7:0] b;
    rst     = 1'b0;
    cts_n   = 1'b0;
    cfg_div = 16'd4;
    for (int i = 0; i < N; i++) lock_en[i] = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    t = cyc;
    for (int r = 0; r < N; r++) push(r, 8'($urandom));
    push(0, 8'($urandom));
    model_run(t, 4, 4);
    finish_check("rr");

    t = cyc;
    push(1, 8'h65);
    model_run(t, 4, 4);
    finish_check("single");

    t = cyc;
    push(1, 8'($urandom));
    push(2, 8'($urandom));
    model_run(t, 4, 4);
    finish_check("favour");

    t = cyc;
    lock_en[2] = 1'b1;
    push(2, 8'hA5);
    push(2, 8'h5A);
    push(2, 8'hFF);
    push(0, 8'($urandom));
    model_run(t, 4, 4);
    finish_check("lock");
    lock_en[2] = 1'b0;

    cts_n = 1'b1;
    b     = 8'($urandom);
    dq[3].push_back(b);
    viol  = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (grant !== '0 || tx !== 1'b1) viol++;
    end
    chk("cts_hold", 32'(viol), 32'd0);
    cts_n = 1'b0;
    t     = cyc;
    mq[3].push_back(b);
    model_run(t, 4, 4);
    goto(expq[0].s + 15);
    cts_n = 1'b1;
    b     = 8'($urandom);
    dq[0].push_back(b);
    finish_check("cts_mid");
    repeat (30) @(posedge clk);
    #1;
    chk("cts_block_grant", 32'(grant), 32'd0);
    chk("cts_block_line", 32'(tx), 32'd1);
    cts_n = 1'b0;
    t     = cyc;
    mq[0].push_back(b);
    model_run(t, 4, 4);
    finish_check("cts_resume");

    t = cyc;
    b = 8'($urandom) & 8'hF7;
    dq[0].push_back(b);
    goto(t + 2 + 17);
    chk("rst_mid_pre", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_frames", 32'(frames), 32'd0);
    mframes = 0;
    mptr    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    t = cyc;
    push(0, 8'($urandom));
    model_run(t, 4, 4);
    finish_check("post_rst");

    cfg_div = 16'd0;
    t       = cyc;
    push(2, 8'($urandom));
    model_run(t, 1, 1);
    finish_check("div0");

    cfg_div = 16'd4;
    t       = cyc;
    push(1, 8'($urandom));
    push(1, 8'($urandom));
    model_run(t, 4, 8);
    goto(t + 12);
    cfg_div = 16'd8;
    finish_check("div_chg");

    for (int it = 0; it < 4; it++) begin
      t       = cyc;
      d       = $urandom_range(1, 5);
      cfg_div = 16'(d);
      any     = 1'b0;
      for (int r = 0; r < N; r++) begin
        lock_en[r] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1 || (r == N - 1 && !any)) begin
          any = 1'b1;
          n   = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) push(r, 8'($urandom));
        end
      end
      model_run(t, d, d);
      finish_check($sformatf("rnd%0d", it));
      for (int r = 0; r < N; r++) lock_en[r] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
